// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port register file with an integrated pending-write
//   scoreboard. Reads are registered (one cycle latency) and see the writes
//   and scoreboard updates of the same clock edge (write-first bypass).
//
// Parameters
//   DATA_W     register width in bits
//   ADDR_W     address width, depth = 2**ADDR_W
//   NUM_RD     number of read ports
//   NUM_WR     number of write ports (higher index wins on address clash)
//   ZERO_REG   1: register 0 reads 0, ignores writes, never pending
//   RESET_MODE 0: registers reset to 0, 1: register i resets to i
//
// Ports
//   clk        rising-edge clock
//   Rst        asynchronous active-high reset
//   rd_en      per-port read enable
//   rd_addr    read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data    registered read data, port p at [p*DATA_W +: DATA_W]
//   rd_ready   registered, 1 = returned value is not awaiting a producer
//   wr_en      per-port write enable
//   wr_addr    write addresses, same packing as rd_addr
//   wr_data    write data, same packing as rd_data
//   alloc_en   mark alloc_addr as pending
//   alloc_addr destination register being allocated
//   pending    registered scoreboard bits, one per register
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int ZERO_REG   = 1,
    parameter int RESET_MODE = 1
) (
    input  logic                       clk,
    input  logic                       Rst,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_ready,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       alloc_en,
    input  logic [ADDR_W-1:0]          alloc_addr,
    output logic [(2**ADDR_W)-1:0]     pending
);

    localparam int DEPTH = 2**ADDR_W;

    // Post-edge view of every register and scoreboard bit. The read ports
    // sample these so a same-edge write or alloc is visible immediately.
    logic [DATA_W-1:0] regs_next [DEPTH];
    logic [DEPTH-1:0]  pending_reg;
    logic [DEPTH-1:0]  pending_next;

    genvar gi;

    // -----------------------------------------------------------------------
    // Storage and scoreboard, one slice per register
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] ADDR    = ADDR_W'(gi);
            localparam bit                IS_ZERO = (ZERO_REG != 0) && (gi == 0);
            localparam logic [DATA_W-1:0] RST_VAL =
                ((RESET_MODE != 0) && !IS_ZERO) ? DATA_W'(gi) : {DATA_W{1'b0}};

            logic [DATA_W-1:0] data_reg;
            logic [DATA_W-1:0] data_next;
            logic              wr_hit;
            logic              alloc_hit;
            logic              pend_reg;
            logic              pend_next;

            // Scan write ports in ascending order so the highest-indexed
            // matching port is the last assignment and therefore wins.
            always_comb begin
                data_next = data_reg;
                wr_hit    = 1'b0;
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ADDR)) begin
                        data_next = wr_data[w*DATA_W +: DATA_W];
                        wr_hit    = 1'b1;
                    end
                end
                if (IS_ZERO) begin
                    data_next = {DATA_W{1'b0}};
                end
            end

            assign alloc_hit = alloc_en && (alloc_addr == ADDR);

            // A same-edge alloc beats the write: the write belongs to the
            // older producer, the alloc announces a newer one.
            always_comb begin
                pend_next = alloc_hit || (pend_reg && !wr_hit);
                if (IS_ZERO) begin
                    pend_next = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge Rst) begin
                if (Rst) begin
                    data_reg <= RST_VAL;
                    pend_reg <= 1'b0;
                end else begin
                    data_reg <= data_next;
                    pend_reg <= pend_next;
                end
            end

            assign regs_next[gi]    = data_next;
            assign pending_next[gi] = pend_next;
            assign pending_reg[gi]  = pend_reg;
        end
    endgenerate

    assign pending = pending_reg;

    // -----------------------------------------------------------------------
    // Read ports: registered, sampling the post-edge state. Register 0 needs
    // no special case here because its next value and pending bit are
    // already forced to zero above when ZERO_REG is set.
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data_reg;
            logic              ready_reg;

            assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

            always_ff @(posedge clk or posedge Rst) begin
                if (Rst) begin
                    data_reg  <= {DATA_W{1'b0}};
                    ready_reg <= 1'b1;
                end else if (rd_en[gi]) begin
                    data_reg  <= regs_next[addr];
                    ready_reg <= !pending_next[addr];
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = data_reg;
            assign rd_ready[gi]                 = ready_reg;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Self-checking bench for regfile_mp (default parameters). Directed cases
//   with literal expectations, then randomized traffic checked every cycle
//   against an array/bit-vector model of the register file and scoreboard.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NR  = 2;
    localparam int NW  = 2;
    localparam int DEP = 32;

    logic               clk = 1'b0;
    logic               Rst = 1'b0;
    logic [NR-1:0]      rd_en = '0;
    logic [NR*AW-1:0]   rd_addr = '0;
    logic [NR*DW-1:0]   rd_data;
    logic [NR-1:0]      rd_ready;
    logic [NW-1:0]      wr_en = '0;
    logic [NW*AW-1:0]   wr_addr = '0;
    logic [NW*DW-1:0]   wr_data = '0;
    logic               alloc_en = 1'b0;
    logic [AW-1:0]      alloc_addr = '0;
    logic [DEP-1:0]     pending;

    regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
        .ZERO_REG(1), .RESET_MODE(1)
    ) dut (
        .clk(clk), .Rst(Rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .pending(pending)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: register contents, scoreboard, last read results
    logic [DW-1:0]  m_regs [DEP];
    logic [DEP-1:0] m_pend;
    logic [DW-1:0]  m_rd   [NR];
    logic           m_rdy  [NR];
    bit             model_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) m_regs[i] = DW'(i);
        m_regs[0] = '0;
        m_pend = '0;
        for (int p = 0; p < NR; p++) begin
            m_rd[p]  = '0;
            m_rdy[p] = 1'b1;
        end
        model_valid = 1'b1;
    endtask

    // One clock edge of architectural behaviour: writes in port order (later
    // port overrides), scoreboard clears then alloc sets, reads see result.
    task automatic model_step();
        logic [AW-1:0] a;
        for (int w = 0; w < NW; w++) begin
            if (wr_en[w]) begin
                a = wr_addr[w*AW +: AW];
                if (a != 0) m_regs[a] = wr_data[w*DW +: DW];
                m_pend[a] = 1'b0;
            end
        end
        if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
        m_pend[0] = 1'b0;
        for (int p = 0; p < NR; p++) begin
            if (rd_en[p]) begin
                a = rd_addr[p*AW +: AW];
                m_rd[p]  = m_regs[a];
                m_rdy[p] = !m_pend[a];
            end
        end
    endtask

    // Advance one edge, update the model from the inputs seen at that edge,
    // then return 1 time unit later so outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        if (Rst) model_reset();
        else if (model_valid) model_step();
        #1;
    endtask

    task automatic idle();
        rd_en = '0; wr_en = '0; alloc_en = 1'b0;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_valid && !Rst) begin
            for (int p = 0; p < NR; p++) begin
                chk($sformatf("rd_data[%0d]", p), 64'(rd_data[p*DW +: DW]), 64'(m_rd[p]));
                chk($sformatf("rd_ready[%0d]", p), 64'(rd_ready[p]), 64'(m_rdy[p]));
            end
            chk("pending", 64'(pending), 64'(m_pend));
        end
    end

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom);
    endfunction

    initial begin
        // ---- asynchronous reset between edges ----
        #3 Rst = 1'b1;
        model_reset();
        #1;
        $display("txn reset asserted");
        chk("reset rd_data", 64'(rd_data), 64'h0);
        chk("reset rd_ready", 64'(rd_ready), 64'h3);
        chk("reset pending", 64'(pending), 64'h0);
        tick();
        Rst = 1'b0;

        // ---- reset values of reg 7 and reg 31 ----
        rd_en = 2'b11; rd_addr = {5'd31, 5'd7};
        $display("txn read r7 / r31");
        tick();
        chk("reset r7", 64'(rd_data[31:0]), 64'h7);
        chk("reset r31", 64'(rd_data[63:32]), 64'h1F);
        chk("reset ready", 64'(rd_ready), 64'h3);
        idle();

        // ---- write-first bypass ----
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        rd_en = 2'b10; rd_addr = {5'd5, 5'd0};
        $display("txn bypass wr r5 rd r5");
        tick();
        chk("bypass", 64'(rd_data[63:32]), 64'hDEADBEEF);
        idle();

        // ---- write port conflict ----
        wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h22222222, 32'h11111111};
        $display("txn conflict wr r9");
        tick();
        idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
        tick();
        chk("conflict", 64'(rd_data[31:0]), 64'h22222222);
        idle();

        // ---- zero register ----
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF};
        alloc_en = 1'b1; alloc_addr = 5'd0;
        $display("txn zero reg write+alloc");
        tick();
        idle();
        rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
        tick();
        chk("zero data", 64'(rd_data), 64'h0);
        chk("zero ready", 64'(rd_ready), 64'h3);
        chk("zero pending", 64'(pending[0]), 64'h0);
        idle();

        // ---- scoreboard alloc / clear / alloc+write ----
        alloc_en = 1'b1; alloc_addr = 5'd12;
        $display("txn alloc r12");
        tick();
        idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd12};
        tick();
        chk("alloc ready", 64'(rd_ready[0]), 64'h0);
        chk("alloc pending", 64'(pending[12]), 64'h1);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'h55};
        $display("txn write r12 with read");
        tick();
        chk("clear data", 64'(rd_data[31:0]), 64'h55);
        chk("clear ready", 64'(rd_ready[0]), 64'h1);
        chk("clear pending", 64'(pending[12]), 64'h0);
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd12;
        wr_en = 2'b10; wr_addr = {5'd12, 5'd0}; wr_data = {32'h66, 32'h0};
        $display("txn alloc+write r12");
        tick();
        chk("alloc wins", 64'(pending[12]), 64'h1);
        idle();

        // ---- reset mid-operation ----
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hABCD};
        tick();
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd3;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        $display("txn alloc r3 + read r3");
        tick();
        chk("pre-reset data", 64'(rd_data[31:0]), 64'hABCD);
        chk("pre-reset pending", 64'(pending[3]), 64'h1);
        idle();
        #1 Rst = 1'b1;
        model_reset();
        #1;
        $display("txn mid-operation reset");
        chk("midrst rd_data", 64'(rd_data), 64'h0);
        chk("midrst pending", 64'(pending), 64'h0);
        chk("midrst ready", 64'(rd_ready), 64'h3);
        Rst = 1'b0;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        tick();
        chk("midrst r3", 64'(rd_data[31:0]), 64'h3);
        idle();

        // ---- randomized traffic ----
        for (int i = 0; i < 1000; i++) begin
            rd_en    = NR'($urandom);
            wr_en    = NW'($urandom);
            alloc_en = 1'($urandom);
            alloc_addr = pick_addr();
            for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = pick_addr();
            for (int w = 0; w < NW; w++) begin
                wr_addr[w*AW +: AW] = pick_addr();
                wr_data[w*DW +: DW] = $urandom;
            end
            if ($urandom_range(0, 199) == 0) begin
                #2 Rst = 1'b1;
                model_reset();
                #1;
                chk("rand reset rd_data", 64'(rd_data), 64'h0);
                Rst = 1'b0;
                $display("txn %0d async reset", i);
            end
            $display("txn %0d rd_en=%b rd_addr=%h wr_en=%b wr_addr=%h alloc=%b/%0d",
                     i, rd_en, rd_addr, wr_en, wr_addr, alloc_en, alloc_addr);
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the CPU datapath; next generation of the 2-read/1-write register file.
- Configurable width, depth, read-port and write-port counts.
- Synchronous (registered) reads with same-cycle write-to-read bypass.
- Integrated pending-write scoreboard: decode can tell whether a source register is awaiting a producer.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending.
- RESET_MODE, 1, 0: all registers reset to 0; 1: register i resets to i (zero-extended; register 0 still 0 if ZERO_REG=1).

Ports:
- clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port p at bits [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  registered read data, same packing.
- rd_ready  out  NUM_RD  registered; 1 = value returned on rd_data is architecturally final (not pending).
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- alloc_en  in  1  marks alloc_addr as pending (producer issued).
- alloc_addr  in  ADDR_W  destination being allocated.
- pending  out  2**ADDR_W  current scoreboard bits, registered.

Behaviour:
- Reset (Rst high, asynchronous, no clock needed):
  - Array loaded per RESET_MODE.
  - rd_data = 0, rd_ready = all 1s, pending = 0.
  - Reset takes effect mid-operation immediately; any in-flight read or write in that cycle is discarded.
- Write:
  - On posedge, each port with wr_en=1 updates reg[wr_addr].
  - Two ports targeting the same address in one cycle: the highest-indexed port wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read, latency 1:
  - On posedge with rd_en[p]=1, rd_data[p] <= value of reg[rd_addr[p]] after that edge's writes are applied (write-first bypass, highest write port wins).
  - rd_en[p]=0 holds rd_data[p] and rd_ready[p] unchanged.
  - Address 0 with ZERO_REG=1 always returns 0, ready=1.
- Scoreboard:
  - On posedge, alloc_en sets pending[alloc_addr].
  - Any wr_en to address a clears pending[a].
  - Same-edge alloc and write to the same address: pending stays set (the newer producer wins).
  - alloc to address 0 with ZERO_REG=1 is ignored.
  - Allocating an already-pending register is legal; the bit stays 1.
- rd_ready[p] timing:
  - Registered on the same edge as rd_data[p].
  - Value = NOT pending[rd_addr[p]], evaluated after that edge's alloc/write updates, using the same rule as the pending register.
- Reads of all ports are independent; identical addresses on several ports return identical data.
- No combinational path from any input to any output.
- Implementation budget: array of 2**ADDR_W x DATA_W flops; generate loops over ports.

Test Plan:
- Reset with RESET_MODE=1: assert Rst asynchronously between edges, then read addr 7 on port 0 and addr 31 on port 1 -> next cycle rd_data = 0x00000007 / 0x0000001F; rd_ready=2'b11; pending=0.
- Bypass: wr port0 addr 5 data 0xDEADBEEF and rd port1 addr 5 in the same cycle -> next cycle rd_data[1]=0xDEADBEEF.
- Write conflict: port0 addr 9 data 0x11111111 and port1 addr 9 data 0x22222222 in the same cycle; read addr 9 next cycle -> 0x22222222.
- Zero register: write addr 0 data 0xFFFFFFFF and alloc addr 0 -> read addr 0 returns 0, rd_ready=1, pending[0]=0.
- Scoreboard:
  - alloc addr 12 -> read addr 12 next cycle gives rd_ready=0, pending[12]=1.
  - Then write addr 12 data 0x55 with a same-cycle read -> rd_data=0x55, rd_ready=1, pending[12]=0.
  - Same-edge alloc+write addr 12 -> pending[12] stays 1.
- Reset mid-operation: with pending[3]=1 and reg 3 written to 0xABCD, pulse Rst -> pending=0, reg 3 reads 0x00000003, rd_data outputs 0 immediately on Rst assertion.
